// File: rtl/wf_rgb_pkg.sv
// Shared state encodings, pixel field layout and the PWM level extraction for the RGB scan driver.
// Pure definitions: no latency and no flow control.
package wf_rgb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int R_LSB   = 10;
    localparam int G_LSB   = 5;
    localparam int B_LSB   = 0;
    localparam int FIELD_W = 5;

    // Top pwm_bits of the selected 5-bit colour field, right aligned.
    function automatic logic [FIELD_W-1:0] level_of(input logic [15:0] pixel,
                                                    input int field,
                                                    input int pwm_bits);
        logic [FIELD_W-1:0] f;
        f = pixel[field +: FIELD_W];
        return f >> (FIELD_W - pwm_bits);
    endfunction

endpackage

// File: rtl/wf_rgb_serializer.sv
// Shifts an N-bit word MSB first as CLK_OUT/DOUT over 2N cycles; done marks the last cycle.
// No backpressure: a load restarts the shift unconditionally.
module wf_rgb_serializer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] word,
    output logic         clk_out,
    output logic         dout,
    output logic         done
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * N - 1);

    logic [N-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh     <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            sh     <= word;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == CNT_LAST) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Advance data only as the shift clock falls, so DOUT is stable around each rise.
            if (cnt[0]) begin
                sh <= sh << 1;
            end
        end
    end

    assign clk_out = active & cnt[0];
    assign dout    = active & sh[N-1];
    assign done    = active && (cnt == CNT_LAST);

endmodule

// File: rtl/wf_rgb_pwm_scan.sv
// Row-scan RGB matrix driver: reads one row of pixels, PWM-compares each colour, shifts the row out.
// scan_done fires COLS+2+6*COLS+2*ROWS cycles after scan_en; scan_en while busy is dropped and flagged as overrun.
module wf_rgb_pwm_scan
    import wf_rgb_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int PWM_BITS       = 4,
    parameter int COL_ACTIVE_LOW = 1,
    parameter int AW             = $clog2(ROWS * COLS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_en,
    input  logic                      blank,
    output logic [AW-1:0]             ram_rd_addr,
    input  logic [15:0]               ram_rd_pixels,
    output logic                      scan_done,
    output logic                      busy,
    output logic                      overrun,
    output logic [$clog2(ROWS)-1:0]   row_idx,
    output logic [PWM_BITS-1:0]       pwm_cnt,
    output logic                      CLK_OUT,
    output logic                      LOAD,
    output logic                      DOUT
);

    localparam int N  = 3 * COLS + ROWS;
    localparam int CW = $clog2(COLS + 1);
    localparam logic OFF_BIT = 1'(COL_ACTIVE_LOW);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(2 ** PWM_BITS - 2);

    state_t           state;
    logic [CW-1:0]    rd_cnt;
    logic [AW-1:0]    rd_addr;
    logic             blank_q;
    logic [COLS-1:0]  g_q, r_q, b_q;
    logic [COLS-1:0]  g_nxt, r_nxt, b_nxt;
    logic [ROWS-1:0]  row_bits;
    logic             g_bit, r_bit, b_bit;
    logic             ser_load, ser_done;
    logic [N-1:0]     word;

    // Column bits for the pixel arriving this cycle, already in display polarity.
    always_comb begin
        g_bit = OFF_BIT;
        r_bit = OFF_BIT;
        b_bit = OFF_BIT;
        if (!blank_q) begin
            g_bit = (level_of(ram_rd_pixels, G_LSB, PWM_BITS) > FIELD_W'(pwm_cnt)) ^ OFF_BIT;
            r_bit = (level_of(ram_rd_pixels, R_LSB, PWM_BITS) > FIELD_W'(pwm_cnt)) ^ OFF_BIT;
            b_bit = (level_of(ram_rd_pixels, B_LSB, PWM_BITS) > FIELD_W'(pwm_cnt)) ^ OFF_BIT;
        end
    end

    // The last column lands in the same cycle the serializer loads, so the word uses next-state slots.
    always_comb begin
        g_nxt = g_q;
        r_nxt = r_q;
        b_nxt = b_q;
        for (int c = 0; c < COLS; c++) begin
            if (state == ST_READ && int'(rd_cnt) == c + 1) begin
                g_nxt[c] = g_bit;
                r_nxt[c] = r_bit;
                b_nxt[c] = b_bit;
            end
        end
    end

    always_comb begin
        row_bits = '1;
        for (int r = 0; r < ROWS; r++) begin
            row_bits[r] = blank_q || (int'(row_idx) != r);
        end
    end

    assign word     = {g_nxt, r_nxt, b_nxt, row_bits};
    assign ser_load = (state == ST_READ) && (int'(rd_cnt) == COLS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            rd_cnt  <= '0;
            rd_addr <= '0;
            blank_q <= 1'b0;
            row_idx <= '0;
            pwm_cnt <= '0;
            g_q     <= {COLS{OFF_BIT}};
            r_q     <= {COLS{OFF_BIT}};
            b_q     <= {COLS{OFF_BIT}};
        end else begin
            g_q <= g_nxt;
            r_q <= r_nxt;
            b_q <= b_nxt;
            case (state)
                ST_IDLE: begin
                    if (scan_en) begin
                        state   <= ST_READ;
                        blank_q <= blank;
                        rd_cnt  <= '0;
                        rd_addr <= AW'(row_idx) * AW'(COLS);
                    end
                end
                ST_READ: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (int'(rd_cnt) < COLS - 1) begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                    if (int'(rd_cnt) == COLS) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_done) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (int'(row_idx) == ROWS - 1) begin
                        row_idx <= '0;
                        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ram_rd_addr = rd_addr;
    assign busy        = (state != ST_IDLE);
    assign overrun     = scan_en && busy;
    assign scan_done   = (state == ST_DONE);
    assign LOAD        = (state != ST_SHIFT);

    wf_rgb_serializer #(.N(N)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_load),
        .word    (word),
        .clk_out (CLK_OUT),
        .dout    (DOUT),
        .done    (ser_done)
    );

endmodule

// File: tb/tb_wf_rgb_pwm_scan.sv
// Scoreboard bench: two configurations of the scan driver against directed row scans.
module tb_wf_rgb_pwm_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, scan_en1, blank1, scan_done1, busy1, overrun1, CLK_OUT1, LOAD1, DOUT1;
    logic [5:0]  addr1;
    logic [15:0] px1;
    logic [2:0]  row1;
    logic [3:0]  pwm1;

    logic        rst2, scan_en2, blank2, scan_done2, busy2, overrun2, CLK_OUT2, LOAD2, DOUT2;
    logic [4:0]  addr2;
    logic [15:0] px2;
    logic [1:0]  row2;
    logic [1:0]  pwm2;

    logic [15:0] mem1 [64];
    logic [15:0] mem2 [24];

    always @(posedge clk) begin
        px1 <= mem1[addr1];
        px2 <= mem2[addr2];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wf_rgb_pwm_scan dut1 (
        .clk(clk), .reset(rst1), .scan_en(scan_en1), .blank(blank1),
        .ram_rd_addr(addr1), .ram_rd_pixels(px1), .scan_done(scan_done1),
        .busy(busy1), .overrun(overrun1), .row_idx(row1), .pwm_cnt(pwm1),
        .CLK_OUT(CLK_OUT1), .LOAD(LOAD1), .DOUT(DOUT1)
    );

    wf_rgb_pwm_scan #(.ROWS(4), .COLS(6), .PWM_BITS(2), .COL_ACTIVE_LOW(0)) dut2 (
        .clk(clk), .reset(rst2), .scan_en(scan_en2), .blank(blank2),
        .ram_rd_addr(addr2), .ram_rd_pixels(px2), .scan_done(scan_done2),
        .busy(busy2), .overrun(overrun2), .row_idx(row2), .pwm_cnt(pwm2),
        .CLK_OUT(CLK_OUT2), .LOAD(LOAD2), .DOUT(DOUT2)
    );

    typedef struct {
        int          done_cyc;
        logic [63:0] word;
        int          nbits;
        int          base;
        int          ncols;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    logic [63:0] cap [2];
    int          cap_n [2];
    logic        prev_c [2];
    int          ak [2];
    int          addrs [2][16];
    int          ld_bad [2];
    logic [63:0] last_word [2];

    task automatic mon_step(input int d, input logic rst, input logic sd, input logic clko,
                            input logic dout, input logic ld, input logic bsy, input int addr);
        exp_t e;
        logic got;
        if (rst) begin
            cap[d] = '0; cap_n[d] = 0; prev_c[d] = 1'b0; ak[d] = 0; ld_bad[d] = 0;
        end else begin
            if (clko && !prev_c[d]) begin
                cap[d] = {cap[d][62:0], dout};
                cap_n[d]++;
                if (ld) ld_bad[d]++;
            end
            prev_c[d] = clko;
            if (bsy && ld && !sd && ak[d] < 16) begin
                addrs[d][ak[d]] = addr;
                ak[d]++;
            end
            if (sd) begin
                got = 1'b0;
                if (d == 0 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                else if (d == 1 && q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                if (!got) begin
                    chk($sformatf("dut%0d unexpected scan_done", d), 64'd1, 64'd0);
                end else begin
                    chk($sformatf("dut%0d done cycle", d), 64'(cyc), 64'(e.done_cyc));
                    chk($sformatf("dut%0d clk rises", d), 64'(cap_n[d]), 64'(e.nbits));
                    chk($sformatf("dut%0d shifted word", d), cap[d], e.word);
                    chk($sformatf("dut%0d rises with LOAD high", d), 64'(ld_bad[d]), 64'd0);
                    chk($sformatf("dut%0d read cycles", d), 64'(ak[d]), 64'(e.ncols + 1));
                    for (int k = 0; k < e.ncols; k++)
                        chk($sformatf("dut%0d addr[%0d]", d, k), 64'(addrs[d][k]), 64'(e.base + k));
                end
                last_word[d] = cap[d];
                cap[d] = '0; cap_n[d] = 0; ak[d] = 0; ld_bad[d] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, rst1, scan_done1, CLK_OUT1, DOUT1, LOAD1, busy1, int'(addr1));
        mon_step(1, rst2, scan_done2, CLK_OUT2, DOUT2, LOAD2, busy2, int'(addr2));
    end

    function automatic logic [7:0] rb8(input int r);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << r);
    endfunction

    function automatic logic [3:0] rb4(input int r);
        logic [3:0] one;
        one = 4'd1;
        return ~(one << r);
    endfunction

    // Issues scan_en in one cycle and flips blank afterwards (it must have no effect mid-scan).
    task automatic scan1(input logic b, input logic push, input logic [63:0] w, input int row);
        exp_t e;
        @(posedge clk); #1;
        scan_en1 = 1'b1; blank1 = b;
        e.done_cyc = cyc + 74; e.word = w; e.nbits = 32; e.base = row * 8; e.ncols = 8;
        if (push) q1.push_back(e);
        @(posedge clk); #1;
        scan_en1 = 1'b0; blank1 = ~b;
    endtask

    task automatic scan2(input logic [63:0] w, input int row);
        exp_t e;
        @(posedge clk); #1;
        scan_en2 = 1'b1; blank2 = 1'b0;
        e.done_cyc = cyc + 52; e.word = w; e.nbits = 22; e.base = row * 6; e.ncols = 6;
        q2.push_back(e);
        @(posedge clk); #1;
        scan_en2 = 1'b0; blank2 = 1'b1;
    endtask

    task automatic wait1();
        repeat (75) @(posedge clk);
        #1;
    endtask

    int lit;
    logic [7:0] g;
    logic [5:0] g2;

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        scan_en1 = 1'b0; scan_en2 = 1'b0; blank1 = 1'b0; blank2 = 1'b0;
        for (int i = 0; i < 64; i++) mem1[i] = 16'h7FFF;
        // R level 3, G level 1, B level 0 at two PWM bits.
        for (int i = 0; i < 24; i++) mem2[i] = 16'h6100;
        repeat (2) @(posedge clk); #1;

        chk("reset LOAD", 64'(LOAD1), 64'd1);
        chk("reset CLK_OUT", 64'(CLK_OUT1), 64'd0);
        chk("reset DOUT", 64'(DOUT1), 64'd0);
        chk("reset busy", 64'(busy1), 64'd0);
        chk("reset scan_done", 64'(scan_done1), 64'd0);
        chk("reset overrun", 64'(overrun1), 64'd0);
        chk("reset row_idx", 64'(row1), 64'd0);
        chk("reset pwm_cnt", 64'(pwm1), 64'd0);
        chk("reset ram_rd_addr", 64'(addr1), 64'd0);
        rst1 = 1'b0; rst2 = 1'b0;

        // All lit, active-low columns: 24 zeros, then rows 7..0 with row 0 low.
        scan1(1'b0, 1'b1, {24'h0, rb8(0)}, 0);
        wait1();
        chk("row after scan 0", 64'(row1), 64'd1);

        // Overrun ten cycles into the scan.
        scan1(1'b0, 1'b1, {24'h0, rb8(1)}, 1);
        repeat (9) @(posedge clk); #1;
        scan_en1 = 1'b1; #1;
        chk("overrun pulse", 64'(overrun1), 64'd1);
        chk("busy during overrun", 64'(busy1), 64'd1);
        @(posedge clk); #1;
        scan_en1 = 1'b0; #1;
        chk("overrun cleared", 64'(overrun1), 64'd0);
        repeat (65) @(posedge clk); #1;
        chk("row after overrun", 64'(row1), 64'd2);

        scan1(1'b1, 1'b1, 64'hFFFF_FFFF, 2);
        wait1();
        chk("row after blank scan", 64'(row1), 64'd3);

        // Reset at SHIFT index 20 of a blanked (all ones) scan.
        scan1(1'b1, 1'b0, 64'h0, 3);
        repeat (29) @(posedge clk); #1;
        chk("shifting before reset LOAD", 64'(LOAD1), 64'd0);
        chk("shifting before reset DOUT", 64'(DOUT1), 64'd1);
        rst1 = 1'b1; #1;
        chk("mid-scan reset LOAD", 64'(LOAD1), 64'd1);
        chk("mid-scan reset CLK_OUT", 64'(CLK_OUT1), 64'd0);
        chk("mid-scan reset DOUT", 64'(DOUT1), 64'd0);
        chk("mid-scan reset busy", 64'(busy1), 64'd0);
        chk("mid-scan reset row_idx", 64'(row1), 64'd0);
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("pwm after reset", 64'(pwm1), 64'd0);
        scan1(1'b0, 1'b1, {24'h0, rb8(0)}, 0);
        wait1();
        chk("row after restart", 64'(row1), 64'd1);

        // PWM: only (row0,col3) has G level 8; lit in frames 0..7 of 15.
        @(posedge clk); #1; rst1 = 1'b1;
        @(posedge clk); #1; rst1 = 1'b0;
        for (int i = 0; i < 64; i++) mem1[i] = 16'h0000;
        mem1[3] = 16'h0200;
        lit = 0;
        for (int i = 0; i < 120; i++) begin
            g = (i % 8 == 0 && i / 8 < 8) ? 8'hF7 : 8'hFF;
            scan1(1'b0, 1'b1, {g, 8'hFF, 8'hFF, rb8(i % 8)}, i % 8);
            wait1();
            if (i % 8 == 0 && last_word[0][27] == 1'b0) lit++;
            if (i == 63) chk("pwm after 8 frames", 64'(pwm1), 64'd8);
        end
        chk("lit frames of 15", 64'(lit), 64'd8);
        chk("pwm wrapped", 64'(pwm1), 64'd0);
        chk("row wrapped", 64'(row1), 64'd0);

        // Small configuration, active-high columns.
        for (int i = 0; i < 12; i++) begin
            g2 = ((i / 4) % 3 == 0) ? 6'h3F : 6'h00;
            scan2({g2, 6'h3F, 6'h00, rb4(i % 4)}, i % 4);
            repeat (53) @(posedge clk); #1;
            if (i % 4 == 3) chk("dut2 pwm_cnt", 64'(pwm2), 64'((i / 4 + 1) % 3));
        end

        repeat (100) @(posedge clk); #1;
        chk("dut1 pending scans", 64'(q1.size()), 64'd0);
        chk("dut2 pending scans", 64'(q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
